// File: rtl/mm_pkg.sv
// Shared sizing constants for the matrix-multiply tile datapath.
package mm_pkg;
  localparam int unsigned T    = 4;
  localparam int unsigned ACCW = 32;
endpackage

// File: rtl/mm_result_drainer.sv
// Snapshots the PE accumulator array on start and streams the requested
// sub-tile row-major over a valid/ready interface.
module mm_result_drainer #(
  parameter int unsigned T    = mm_pkg::T,
  parameter int unsigned ACCW = mm_pkg::ACCW
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [15:0]                    tile_rows,
  input  logic [15:0]                    tile_cols,
  input  logic                           bankset_sel,
  input  logic [T-1:0][T-1:0][ACCW-1:0]  acc_data,
  input  logic [T-1:0][T-1:0]            acc_valid,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACCW-1:0]                out_data,
  output logic [15:0]                    out_row,
  output logic [15:0]                    out_col,
  output logic                           out_last,
  output logic                           out_bank
);

  localparam int unsigned CW = $clog2(T) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [CW-1:0]                 row_q, row_d;
  logic [CW-1:0]                 col_q, col_d;
  logic [CW-1:0]                 rows_q, cols_q;
  logic                          bank_q;
  logic                          err_q, err_d;
  logic [T-1:0][T-1:0][ACCW-1:0] snap_q;
  logic                          capture;
  logic                          req_bad;
  logic                          is_last;

  always_comb begin
    req_bad = (tile_rows == '0) || (32'(tile_rows) > T) ||
              (tile_cols == '0) || (32'(tile_cols) > T);
    for (int unsigned r = 0; r < T; r++) begin
      for (int unsigned c = 0; c < T; c++) begin
        if (r < 32'(tile_rows) && c < 32'(tile_cols) && !acc_valid[r][c])
          req_bad = 1'b1;
      end
    end
  end

  assign is_last = (row_q == rows_q - 1'b1) && (col_q == cols_q - 1'b1);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    err_d   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            capture = 1'b1;
            row_d   = '0;
            col_d   = '0;
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (is_last) begin
            state_d = DONE;
          end else if (col_q < cols_q - 1'b1) begin
            col_d = col_q + 1'b1;
          end else begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      bank_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      err_q   <= err_d;
      if (capture) begin
        rows_q <= tile_rows[CW-1:0];
        cols_q <= tile_cols[CW-1:0];
        bank_q <= bankset_sel;
      end
    end
  end

  // Snapshot needs no reset: it is only observed while streaming.
  always_ff @(posedge clk) begin
    if (capture) snap_q <= acc_data;
  end

  always_comb begin
    busy      = (state_q == STREAM);
    done      = (state_q == DONE);
    err       = err_q;
    out_valid = (state_q == STREAM);
    out_bank  = bank_q;
    out_data  = '0;
    out_row   = '0;
    out_col   = '0;
    out_last  = 1'b0;
    if (state_q == STREAM) begin
      out_data = snap_q[row_q[CW-2:0]][col_q[CW-2:0]];
      out_row  = 16'(row_q);
      out_col  = 16'(col_q);
      out_last = is_last;
    end
  end

endmodule

// File: tb/tb_mm_result_drainer.sv
// Directed bench for mm_result_drainer with T=4 and hand-computed beats.
module tb_mm_result_drainer;

  localparam int unsigned T    = 4;
  localparam int unsigned ACCW = 32;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          start;
  logic [15:0]                   tile_rows;
  logic [15:0]                   tile_cols;
  logic                          bankset_sel;
  logic [T-1:0][T-1:0][ACCW-1:0] acc_data;
  logic [T-1:0][T-1:0]           acc_valid;
  logic                          busy, done, err, out_valid, out_ready;
  logic [ACCW-1:0]               out_data;
  logic [15:0]                   out_row, out_col;
  logic                          out_last, out_bank;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mm_result_drainer #(.T(T), .ACCW(ACCW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .tile_rows(tile_rows), .tile_cols(tile_cols), .bankset_sel(bankset_sel),
    .acc_data(acc_data), .acc_valid(acc_valid),
    .busy(busy), .done(done), .err(err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .out_bank(out_bank)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start so it is sampled at the next edge; returns in cycle 1.
  task automatic kick(input logic [15:0] r, input logic [15:0] c, input logic b);
    start = 1'b1; tile_rows = r; tile_cols = c; bankset_sel = b;
    step();
    start = 1'b0;
  endtask

  task automatic chk_beat(input string tag, input int r, input int c, input bit last, input logic b);
    chk({tag, "_valid"}, 64'(out_valid), 64'(1));
    chk({tag, "_busy"},  64'(busy),      64'(1));
    chk({tag, "_data"},  64'(out_data),  64'(16 * r + c));
    chk({tag, "_row"},   64'(out_row),   64'(r));
    chk({tag, "_col"},   64'(out_col),   64'(c));
    chk({tag, "_last"},  64'(out_last),  64'(last));
    chk({tag, "_bank"},  64'(out_bank),  64'(b));
    chk({tag, "_err"},   64'(err),       64'(0));
    chk({tag, "_done"},  64'(done),      64'(0));
  endtask

  task automatic chk_done(input string tag);
    chk({tag, "_done"},  64'(done),      64'(1));
    chk({tag, "_busy"},  64'(busy),      64'(0));
    chk({tag, "_valid"}, 64'(out_valid), 64'(0));
  endtask

  // Full-rate drain of an R x C tile of the 16*r+c pattern.
  task automatic drain(input string tag, input int rr, input int cc, input logic b);
    kick(16'(rr), 16'(cc), b);
    for (int k = 0; k < rr * cc; k++) begin
      chk_beat(tag, k / cc, k % cc, k == rr * cc - 1, b);
      step();
    end
    chk_done(tag);
    step();
    chk({tag, "_idle_done"}, 64'(done), 64'(0));
  endtask

  task automatic fill_pattern();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        acc_data[r][c] = 32'(16 * r + c);
    acc_valid = '1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  64'(busy),      64'(0));
    chk({tag, "_done"},  64'(done),      64'(0));
    chk({tag, "_err"},   64'(err),       64'(0));
    chk({tag, "_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_last"},  64'(out_last),  64'(0));
    chk({tag, "_data"},  64'(out_data),  64'(0));
    chk({tag, "_row"},   64'(out_row),   64'(0));
    chk({tag, "_col"},   64'(out_col),   64'(0));
    chk({tag, "_bank"},  64'(out_bank),  64'(0));
  endtask

  task automatic expect_reject(input string tag, input logic [15:0] r, input logic [15:0] c);
    kick(r, c, 1'b0);
    chk({tag, "_err"},   64'(err),       64'(1));
    chk({tag, "_busy"},  64'(busy),      64'(0));
    chk({tag, "_valid"}, 64'(out_valid), 64'(0));
    step();
    chk({tag, "_err2"},   64'(err),       64'(0));
    chk({tag, "_busy2"},  64'(busy),      64'(0));
    chk({tag, "_valid2"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tile_rows = '0; tile_cols = '0;
    bankset_sel = 1'b0; out_ready = 1'b1;
    fill_pattern();
    step(); step();
    chk_reset_outputs("rst");
    rst = 1'b0;
    step();
    chk_reset_outputs("post_rst");

    drain("t4x4", 4, 4, 1'b1);

    // 2x3 tile with alternating stall/accept cycles.
    out_ready = 1'b1;
    kick(16'd2, 16'd3, 1'b0);
    chk_beat("bp0", 0, 0, 1'b0, 1'b0);
    step();
    for (int k = 1; k < 6; k++) begin
      out_ready = 1'b0;
      chk_beat("bp_hold", k / 3, k % 3, k == 5, 1'b0);
      step();
      out_ready = 1'b1;
      chk_beat("bp_take", k / 3, k % 3, k == 5, 1'b0);
      step();
    end
    chk_done("bp");
    step();

    // Missing accumulator inside the tile is rejected.
    acc_valid[1][2] = 1'b0;
    expect_reject("accv", 16'd4, 16'd4);
    // Same hole lies outside a 1x2 tile, so that request is legal.
    drain("t1x2", 1, 2, 1'b0);
    acc_valid = '1;

    expect_reject("rows0", 16'd0, 16'd4);
    expect_reject("cols5", 16'd4, 16'd5);
    expect_reject("rows5", 16'd5, 16'd1);

    // Array corruption and a stray start during the stream have no effect.
    kick(16'd4, 16'd4, 1'b1);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        acc_data[r][c] = 32'hDEAD_BEEF;
    for (int k = 0; k < 16; k++) begin
      chk_beat("snap", k / 4, k % 4, k == 15, 1'b1);
      if (k == 5) begin
        start = 1'b1; tile_rows = 16'd0; tile_cols = 16'd0; bankset_sel = 1'b0;
      end
      step();
      start = 1'b0;
    end
    chk_done("snap");
    chk("snap_done_err", 64'(err), 64'(0));
    step();
    fill_pattern();

    // Reset at beat 7 abandons the stream without a done pulse.
    kick(16'd4, 16'd4, 1'b1);
    for (int k = 0; k < 7; k++) begin
      chk_beat("pre_rst", k / 4, k % 4, 1'b0, 1'b1);
      step();
    end
    chk_beat("rst_beat7", 1, 3, 1'b0, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs("mid_rst");
    step();
    chk_reset_outputs("mid_rst2");
    drain("after_rst", 4, 4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
